// File: rtl/axis_pad_if.sv
// AXI4-Stream beat bundle with single-bit keep, shared by the pad input and output sides.
interface axis_pad_if #(
   parameter int WIDTH = 8
);
   logic             tvalid;
   logic             tready;
   logic             tlast;
   logic             tkeep;
   logic [WIDTH-1:0] tdata;

   modport master (output tvalid, tlast, tkeep, tdata, input tready);
   modport slave  (input tvalid, tlast, tkeep, tdata, output tready);
endinterface

// File: rtl/axis_pad.sv
// Pads AXI4-Stream packets to MINLEN counted beats with filler beats; 1-cycle registered output.
// Full throughput while passing; input is held off (s.tready low) only while filler is emitted.
module axis_pad #(
   parameter int               WIDTH    = 8,
   parameter int               MINLEN   = 60,
   parameter logic [WIDTH-1:0] PADVAL   = '0,
   parameter bit               KEEP_PAD = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   axis_pad_if.slave  s,
   axis_pad_if.master m
);
   localparam int            CW    = $clog2(MINLEN + 1);
   localparam logic [CW-1:0] MIN_C = CW'(MINLEN);

   typedef enum logic {PASS, PAD} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [CW-1:0] cnt_next;
   logic [CW-1:0] pad_next;
   logic [CW:0]   cnt_sum;
   logic          slot_free;

   assign slot_free = !m.tvalid || m.tready;
   assign s.tready  = (state == PASS) && slot_free && !reset;

   // Null beats pass through but do not count towards the minimum length.
   assign cnt_sum  = {1'b0, count} + {{CW{1'b0}}, s.tkeep};
   assign cnt_next = (cnt_sum > {1'b0, MIN_C}) ? MIN_C : cnt_sum[CW-1:0];
   assign pad_next = count + CW'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= PASS;
         count    <= '0;
         m.tvalid <= 1'b0;
         m.tlast  <= 1'b0;
         m.tkeep  <= 1'b0;
         m.tdata  <= '0;
      end else if (slot_free) begin
         unique case (state)
            PASS: begin
               m.tvalid <= s.tvalid;
               if (s.tvalid) begin
                  m.tdata <= s.tdata;
                  m.tkeep <= s.tkeep;
                  if (s.tlast && (cnt_next >= MIN_C)) begin
                     m.tlast <= 1'b1;
                     count   <= '0;
                  end else begin
                     // A short packet's tlast moves onto the final filler beat.
                     m.tlast <= 1'b0;
                     count   <= cnt_next;
                     if (s.tlast) begin
                        state <= PAD;
                     end
                  end
               end
            end
            PAD: begin
               m.tvalid <= 1'b1;
               m.tdata  <= PADVAL;
               m.tkeep  <= KEEP_PAD;
               if (pad_next == MIN_C) begin
                  m.tlast <= 1'b1;
                  count   <= '0;
                  state   <= PASS;
               end else begin
                  m.tlast <= 1'b0;
                  count   <= pad_next;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axis_pad.sv
// Drives two pads (KEEP_PAD=1 and KEEP_PAD=0) with one input stream; outputs go to a packet-level model.
module tb_axis_pad;
   localparam int         W  = 8;
   localparam int         ML = 4;
   localparam logic [7:0] PV = 8'hEE;

   typedef struct {
      logic [7:0] d;
      logic       k;
      logic       l;
      int         c;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_vld = 1'b0, s_last = 1'b0, s_keep = 1'b0, m_rdy = 1'b1;
   logic [7:0] s_dat = 8'h00;

   beat_t got_q[2][$];
   beat_t exp_q[2][$];
   int    total = 0, bad = 0, cyc = 0, stab_viol = 0, rdy_diff = 0;
   bit    rnd_rdy = 1'b0;

   always #5 clk = ~clk;

   axis_pad_if #(.WIDTH(W)) sa ();
   axis_pad_if #(.WIDTH(W)) ma ();
   axis_pad_if #(.WIDTH(W)) sb ();
   axis_pad_if #(.WIDTH(W)) mb ();

   assign sa.tvalid = s_vld;
   assign sa.tlast  = s_last;
   assign sa.tkeep  = s_keep;
   assign sa.tdata  = s_dat;
   assign sb.tvalid = s_vld;
   assign sb.tlast  = s_last;
   assign sb.tkeep  = s_keep;
   assign sb.tdata  = s_dat;
   assign ma.tready = m_rdy;
   assign mb.tready = m_rdy;

   axis_pad #(.WIDTH(W), .MINLEN(ML), .PADVAL(PV), .KEEP_PAD(1'b1)) dut_a (
      .clock(clk), .reset(rst), .s(sa), .m(ma));
   axis_pad #(.WIDTH(W), .MINLEN(ML), .PADVAL(PV), .KEEP_PAD(1'b0)) dut_b (
      .clock(clk), .reset(rst), .s(sb), .m(mb));

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rnd_rdy) begin
         #1;
         if (rnd_rdy) m_rdy = ($urandom_range(0, 1) == 1);
      end
   end

   // Output monitor: collects transferred beats and flags outputs that move while stalled.
   beat_t cur[2];
   beat_t pv[2];
   logic  vv[2];
   bit    ph[2] = '{1'b0, 1'b0};
   always @(negedge clk) begin
      if (sa.tready !== sb.tready) rdy_diff++;
      cur[0] = '{ma.tdata, ma.tkeep, ma.tlast, cyc};
      cur[1] = '{mb.tdata, mb.tkeep, mb.tlast, cyc};
      vv[0]  = ma.tvalid;
      vv[1]  = mb.tvalid;
      for (int u = 0; u < 2; u++) begin
         if (ph[u] && (vv[u] !== 1'b1 || cur[u].d !== pv[u].d || cur[u].k !== pv[u].k ||
                       cur[u].l !== pv[u].l))
            stab_viol++;
         if (!rst && vv[u] === 1'b1 && m_rdy) got_q[u].push_back(cur[u]);
         ph[u] = !rst && vv[u] === 1'b1 && !m_rdy;
         pv[u] = cur[u];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic drive_beat(input logic [7:0] d, input logic k, input logic l, output int stall);
      s_vld  = 1'b1;
      s_dat  = d;
      s_keep = k;
      s_last = l;
      stall  = 0;
      while (1) begin
         @(negedge clk);
         if (sa.tready === 1'b1) break;
         stall++;
         if (stall > 500) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=stalled %0d cycles want=accept", stall);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_vld  = 1'b0;
      s_last = 1'b0;
      s_keep = 1'b0;
      s_dat  = 8'h00;
   endtask

   // Packet-level reference: real beats forwarded, then MINLEN minus data-beat count fillers.
   task automatic send_pkt(input logic [7:0] d[$], input logic k[$], input bit gaps,
                           output int first_stall);
      int n = 0;
      int pads;
      int st;
      foreach (k[i]) n += int'(k[i]);
      pads = (n >= ML) ? 0 : ML - n;
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < d.size(); i++)
            exp_q[u].push_back('{d[i], k[i], (i == d.size() - 1) && (pads == 0), 0});
         for (int j = 0; j < pads; j++)
            exp_q[u].push_back('{PV, (u == 0), (j == pads - 1), 0});
      end
      first_stall = 0;
      for (int i = 0; i < d.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         drive_beat(d[i], k[i], (i == d.size() - 1), st);
         if (i == 0) first_stall = st;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (got_q[0].size() >= exp_q[0].size() && got_q[1].size() >= exp_q[1].size()) break;
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      for (int u = 0; u < 2; u++) begin
         got_q[u].delete();
         exp_q[u].delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_rdy = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (ma.tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", ma.tvalid); end
      total++; if (ma.tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b want=0", ma.tlast); end
      total++; if (ma.tkeep !== 1'b0) begin bad++; $display("FAIL rst_tkeep got=%b want=0", ma.tkeep); end
      total++; if (ma.tdata !== 8'h00) begin bad++; $display("FAIL rst_tdata got=%h want=00", ma.tdata); end
      total++; if (sa.tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", sa.tready); end
      total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid_b got=%b want=0", mb.tvalid); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (sa.tready !== 1'b1) begin bad++; $display("FAIL post_rst_tready got=%b want=1", sa.tready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_long();
      logic [7:0] d[$];
      logic       k[$];
      int         fs;
      int         tot_stall = 0;
      clear_q();
      for (int i = 0; i < 6; i++) begin
         d.push_back(8'(8'h10 + i));
         k.push_back(1'b1);
      end
      send_pkt(d, k, 1'b0, fs);
      tot_stall += fs;
      drain();
      total++; if (tot_stall !== 0) begin bad++; $display("FAIL long_stall got=%0d want=0", tot_stall); end
      for (int u = 0; u < 2; u++) begin
         total++;
         if (got_q[u].size() !== exp_q[u].size()) begin
            bad++; $display("FAIL long_len dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
         end
         for (int i = 0; i < exp_q[u].size() && i < got_q[u].size(); i++) begin
            total++;
            if (got_q[u][i].d !== exp_q[u][i].d || got_q[u][i].k !== exp_q[u][i].k || got_q[u][i].l !== exp_q[u][i].l) begin
               bad++; $display("FAIL long_beat%0d dut%0d got=%h/%b/%b want=%h/%b/%b", i, u, got_q[u][i].d, got_q[u][i].k,
                               got_q[u][i].l, exp_q[u][i].d, exp_q[u][i].k, exp_q[u][i].l);
            end
         end
      end
   endtask

   task automatic test_pad();
      logic [7:0] d[$];
      logic       k[$];
      int         fs;
      int         n;
      clear_q();
      d = {8'hA1, 8'hA2};
      k = {1'b1, 1'b1};
      send_pkt(d, k, 1'b0, fs);
      d = {8'hB0, 8'hB1, 8'hB2, 8'hB3};
      k = {1'b1, 1'b1, 1'b1, 1'b1};
      send_pkt(d, k, 1'b0, fs);
      drain();
      total++; if (fs !== 2) begin bad++; $display("FAIL pad_stall got=%0d want=2", fs); end
      n = got_q[0].size();
      total++;
      if (n < 1 || got_q[0][n-1].c - got_q[0][0].c !== n - 1) begin
         bad++; $display("FAIL pad_gapless got=%0d beats over span %0d want=span %0d", n,
                         (n > 0) ? got_q[0][n-1].c - got_q[0][0].c : -1, n - 1);
      end
      for (int u = 0; u < 2; u++) begin
         total++;
         if (got_q[u].size() !== exp_q[u].size()) begin
            bad++; $display("FAIL pad_len dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
         end
         for (int i = 0; i < exp_q[u].size() && i < got_q[u].size(); i++) begin
            total++;
            if (got_q[u][i].d !== exp_q[u][i].d || got_q[u][i].k !== exp_q[u][i].k || got_q[u][i].l !== exp_q[u][i].l) begin
               bad++; $display("FAIL pad_beat%0d dut%0d got=%h/%b/%b want=%h/%b/%b", i, u, got_q[u][i].d, got_q[u][i].k,
                               got_q[u][i].l, exp_q[u][i].d, exp_q[u][i].k, exp_q[u][i].l);
            end
         end
      end
   endtask

   task automatic test_null();
      logic [7:0] d[$];
      logic       k[$];
      int         fs;
      clear_q();
      d = {8'h01, 8'h02, 8'h33};
      k = {1'b1, 1'b1, 1'b0};
      send_pkt(d, k, 1'b0, fs);
      d = {8'h44};
      k = {1'b0};
      send_pkt(d, k, 1'b0, fs);
      drain();
      for (int u = 0; u < 2; u++) begin
         total++;
         if (got_q[u].size() !== exp_q[u].size()) begin
            bad++; $display("FAIL null_len dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
         end
         for (int i = 0; i < exp_q[u].size() && i < got_q[u].size(); i++) begin
            total++;
            if (got_q[u][i].d !== exp_q[u][i].d || got_q[u][i].k !== exp_q[u][i].k || got_q[u][i].l !== exp_q[u][i].l) begin
               bad++; $display("FAIL null_beat%0d dut%0d got=%h/%b/%b want=%h/%b/%b", i, u, got_q[u][i].d, got_q[u][i].k,
                               got_q[u][i].l, exp_q[u][i].d, exp_q[u][i].k, exp_q[u][i].l);
            end
         end
      end
   endtask

   task automatic test_exact();
      logic [7:0] d[$];
      logic       k[$];
      int         fs;
      int         lens[3] = '{4, 3, 8};
      clear_q();
      for (int p = 0; p < 3; p++) begin
         d.delete();
         k.delete();
         for (int i = 0; i < lens[p]; i++) begin
            d.push_back(8'(8'h20 + 16 * p + i));
            k.push_back(1'b1);
         end
         send_pkt(d, k, 1'b0, fs);
      end
      drain();
      for (int u = 0; u < 2; u++) begin
         total++;
         if (got_q[u].size() !== exp_q[u].size()) begin
            bad++; $display("FAIL exact_len dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
         end
         for (int i = 0; i < exp_q[u].size() && i < got_q[u].size(); i++) begin
            total++;
            if (got_q[u][i].d !== exp_q[u][i].d || got_q[u][i].k !== exp_q[u][i].k || got_q[u][i].l !== exp_q[u][i].l) begin
               bad++; $display("FAIL exact_beat%0d dut%0d got=%h/%b/%b want=%h/%b/%b", i, u, got_q[u][i].d, got_q[u][i].k,
                               got_q[u][i].l, exp_q[u][i].d, exp_q[u][i].k, exp_q[u][i].l);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] d[$];
      logic       k[$];
      int         fs;
      int         len;
      clear_q();
      stab_viol = 0;
      rnd_rdy = 1'b1;
      d = {8'hA1, 8'hA2};
      k = {1'b1, 1'b1};
      send_pkt(d, k, 1'b0, fs);
      for (int p = 0; p < 14; p++) begin
         d.delete();
         k.delete();
         len = $urandom_range(1, 7);
         for (int i = 0; i < len; i++) begin
            d.push_back(8'($urandom_range(0, 255)));
            k.push_back($urandom_range(0, 4) != 0);
         end
         send_pkt(d, k, 1'b1, fs);
      end
      rnd_rdy = 1'b0;
      @(posedge clk);
      #2;
      m_rdy = 1'b1;
      drain();
      total++; if (stab_viol !== 0) begin bad++; $display("FAIL rand_stable got=%0d changes want=0", stab_viol); end
      for (int u = 0; u < 2; u++) begin
         total++;
         if (got_q[u].size() !== exp_q[u].size()) begin
            bad++; $display("FAIL rand_len dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
         end
         for (int i = 0; i < exp_q[u].size() && i < got_q[u].size(); i++) begin
            total++;
            if (got_q[u][i].d !== exp_q[u][i].d || got_q[u][i].k !== exp_q[u][i].k || got_q[u][i].l !== exp_q[u][i].l) begin
               bad++; $display("FAIL rand_beat%0d dut%0d got=%h/%b/%b want=%h/%b/%b", i, u, got_q[u][i].d, got_q[u][i].k,
                               got_q[u][i].l, exp_q[u][i].d, exp_q[u][i].k, exp_q[u][i].l);
            end
         end
      end
   endtask

   task automatic test_reset_pad();
      logic [7:0] d[$];
      logic       k[$];
      int         st;
      clear_q();
      m_rdy = 1'b1;
      // Truncated packet: A1, A2 and the first filler escape; the second filler is discarded.
      for (int u = 0; u < 2; u++) begin
         exp_q[u].push_back('{8'hA1, 1'b1, 1'b0, 0});
         exp_q[u].push_back('{8'hA2, 1'b1, 1'b0, 0});
         exp_q[u].push_back('{PV, (u == 0), 1'b0, 0});
      end
      drive_beat(8'hA1, 1'b1, 1'b0, st);
      drive_beat(8'hA2, 1'b1, 1'b1, st);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (ma.tvalid !== 1'b0) begin bad++; $display("FAIL rstpad_tvalid got=%b want=0", ma.tvalid); end
      total++; if (mb.tvalid !== 1'b0) begin bad++; $display("FAIL rstpad_tvalid_b got=%b want=0", mb.tvalid); end
      total++; if (sa.tready !== 1'b1) begin bad++; $display("FAIL rstpad_tready got=%b want=1", sa.tready); end
      @(posedge clk);
      #1;
      d = {8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
      k = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      send_pkt(d, k, 1'b0, st);
      drain();
      for (int u = 0; u < 2; u++) begin
         total++;
         if (got_q[u].size() !== exp_q[u].size()) begin
            bad++; $display("FAIL rstpad_len dut%0d got=%0d want=%0d", u, got_q[u].size(), exp_q[u].size());
         end
         for (int i = 0; i < exp_q[u].size() && i < got_q[u].size(); i++) begin
            total++;
            if (got_q[u][i].d !== exp_q[u][i].d || got_q[u][i].k !== exp_q[u][i].k || got_q[u][i].l !== exp_q[u][i].l) begin
               bad++; $display("FAIL rstpad_beat%0d dut%0d got=%h/%b/%b want=%h/%b/%b", i, u, got_q[u][i].d, got_q[u][i].k,
                               got_q[u][i].l, exp_q[u][i].d, exp_q[u][i].k, exp_q[u][i].l);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_long();
      test_pad();
      test_null();
      test_exact();
      test_random();
      test_reset_pad();
      total++; if (rdy_diff !== 0) begin bad++; $display("FAIL tready_agree got=%0d diffs want=0", rdy_diff); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
